logic_input_trigger_tx: RTL and testbench

- Converts a rising edge on the asynchronous logic input TX into one fixed UART-format serial frame on TX_OUT.
- Frame format: start bit, 8 data bits LSB first, stop bit.
- Sits between a raw trigger/button-style input and a serial line, as a stimulus source for USART receive logic.
- The transmitted byte and the bit period are compile-time parameters.

---
 rtl/logic_input_trigger_tx.sv | 66 ++++++
 tb/tb_logic_input_trigger_tx.sv | 124 ++++++++++++
 2 files changed

// File: rtl/logic_input_trigger_tx.sv
// logic_input_trigger_tx: emits one fixed 8N1 UART frame (LSB first) on TX_OUT
// for every synchronized rising edge of the asynchronous TX input.
module logic_input_trigger_tx #(
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter logic [7:0]  DATA_BYTE    = 8'h41
) (
   input  logic CLK,
   input  logic RESET,
   input  logic TX,
   output logic TX_OUT
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t      state_q;
   logic        s1_q, s2_q, prev_q, tx_out_q;
   logic [7:0]  shift_q;
   logic [2:0]  bit_q;
   logic [15:0] cnt_q;
   logic        rise, bit_end;
   assign rise    = s2_q & ~prev_q;
   assign bit_end = cnt_q == 16'(CLKS_PER_BIT - 1);
   assign TX_OUT  = tx_out_q;
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q  <= IDLE;
         tx_out_q <= 1'b1;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         prev_q   <= 1'b0;
         shift_q  <= '0;
         bit_q    <= '0;
         cnt_q    <= '0;
      end else begin
         s1_q   <= TX;
         s2_q   <= s1_q;
         prev_q <= s2_q;
         cnt_q  <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 16'd1;
         case (state_q)
            IDLE: begin
               tx_out_q <= ~rise;
               if (rise) begin
                  state_q <= START;
                  shift_q <= DATA_BYTE;
                  bit_q   <= '0;
               end
            end
            START: if (bit_end) begin
               state_q  <= DATA;
               tx_out_q <= shift_q[0];
            end
            DATA: if (bit_end) begin
               // the next bit is presented at the same edge the register shifts
               if (bit_q == 3'd7) begin
                  state_q  <= STOP;
                  tx_out_q <= 1'b1;
               end else begin
                  shift_q  <= shift_q >> 1;
                  bit_q    <= bit_q + 3'd1;
                  tx_out_q <= shift_q[1];
               end
            end
            STOP: if (bit_end) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_logic_input_trigger_tx.sv
// tb_logic_input_trigger_tx: directed vector bench for the default build plus a
// CLKS_PER_BIT=4 / 8'hA5 build and a periodic-pulse frame decoder.
module tb_logic_input_trigger_tx;
   typedef struct {
      logic rst_n;
      logic tx;
      logic exp;
   } vec_t;
   localparam logic [9:0] F41 = {1'b1, 8'h41, 1'b0};
   localparam logic [9:0] FA5 = {1'b1, 8'hA5, 1'b0};
   logic CLK = 1'b0;
   logic RESET = 1'b0;
   logic TX = 1'b0;
   logic TX4 = 1'b0;
   logic tx_out, tx_out4;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vq[$];
   always #20 CLK = ~CLK;
   logic_input_trigger_tx dut (
      .CLK(CLK), .RESET(RESET), .TX(TX), .TX_OUT(tx_out)
   );
   logic_input_trigger_tx #(.CLKS_PER_BIT(4), .DATA_BYTE(8'hA5)) dut4 (
      .CLK(CLK), .RESET(RESET), .TX(TX4), .TX_OUT(tx_out4)
   );
   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask
   task automatic push(input logic r, input logic t, input logic e);
      vq.push_back('{rst_n: r, tx: t, exp: e});
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b1);
   endtask
   task automatic pulse();
      push(1'b1, 1'b1, 1'b1);
      push(1'b1, 1'b0, 1'b1);
   endtask
   // one frame of expected outputs; optional TX pulse at tx_at, reset at rst_at
   task automatic frame(input logic tx_base, input int tx_at, input int rst_at);
      for (int i = 0; i < 10; i++) begin
         if (i == rst_at) begin
            push(1'b0, 1'b0, 1'b1);
            return;
         end
         push(1'b1, tx_base | (i == tx_at), F41[i]);
      end
   endtask
   initial begin
      int pos;
      int nfr;
      logic [9:0] sh;
      push(1'b0, 1'b1, 1'b1); push(1'b0, 1'b1, 1'b1);
      push(1'b1, 1'b1, 1'b1); push(1'b1, 1'b1, 1'b1);
      frame(1'b1, -1, -1);
      for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b1);
      idle(3);
      pulse(); frame(1'b0, -1, -1); idle(3);
      pulse(); frame(1'b0, 4, -1); idle(6);
      pulse(); frame(1'b0, 9, -1); idle(1); frame(1'b0, -1, -1); idle(3);
      pulse(); frame(1'b0, -1, 5); idle(12);
      pulse(); frame(1'b0, -1, -1); idle(3);
      for (int k = 0; k < vq.size(); k++) begin
         @(negedge CLK);
         RESET = vq[k].rst_n;
         TX    = vq[k].tx;
         @(posedge CLK); #1;
         check("vec", k, {7'd0, tx_out}, {7'd0, vq[k].exp});
      end
      @(negedge CLK);
      TX4 = 1'b1;
      @(posedge CLK); #1;
      check("cpb4_lat", 0, {7'd0, tx_out4}, 8'd1);
      @(negedge CLK);
      TX4 = 1'b0;
      @(posedge CLK); #1;
      check("cpb4_lat", 1, {7'd0, tx_out4}, 8'd1);
      for (int i = 0; i < 44; i++) begin
         @(posedge CLK); #1;
         check("cpb4_bit", i, {7'd0, tx_out4}, {7'd0, (i < 40) ? FA5[i / 4] : 1'b1});
      end
      @(negedge CLK); #10;
      nfr = 0;
      pos = -1;
      sh  = '0;
      fork
         begin
            #60;
            for (int p = 0; p < 4; p++) begin
               TX = 1'b1;
               #40 TX = 1'b0;
               if (p < 3) #500;
            end
         end
         begin
            repeat (60) begin
               @(posedge CLK); #1;
               if (pos < 0) begin
                  if (!tx_out) begin
                     sh  = '0;
                     pos = 1;
                  end
               end else begin
                  sh[pos] = tx_out;
                  pos++;
                  if (pos == 10) begin
                     check("per_byte", nfr, sh[8:1], 8'h41);
                     check("per_stop", nfr, {7'd0, sh[9]}, 8'd1);
                     nfr++;
                     pos = -1;
                  end
               end
            end
         end
      join
      check("per_frames", 0, 8'(nfr), 8'd4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
